// File: rtl/raycast_column_scheduler.sv
// raycast_column_scheduler: frame sequencer for the slice-height calculator.
// Sweeps columns 0..NUM_COLS-1, issues one begin pulse per column, catches the
// rising edge of the calculator's end level, clamps the height, and hands
// {column, height} to the slice drawer over a valid/ready slot.  One pending
// register lets column n+1 compute while slice n waits on the drawer.
module raycast_column_scheduler #(
    parameter int NUM_COLS    = 160,
    parameter int HEIGHT_W    = 7,
    parameter int MAX_HEIGHT  = 120,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                frame_start,
    input  logic signed [12:0]  playerX,
    input  logic signed [12:0]  playerY,
    input  logic signed [9:0]   angle_X,
    input  logic signed [9:0]   angle_Y,
    output logic signed [12:0]  calc_playerX,
    output logic signed [12:0]  calc_playerY,
    output logic signed [9:0]   calc_angle_X,
    output logic signed [9:0]   calc_angle_Y,
    output logic [7:0]          calc_column,
    output logic                calc_begin,
    input  logic                calc_end,
    input  logic [HEIGHT_W-1:0] calc_slice_size,
    output logic                slice_valid,
    input  logic                slice_ready,
    output logic [7:0]          slice_column,
    output logic [HEIGHT_W-1:0] slice_height,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                err_timeout
);
    localparam int COL_W = 8;
    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_HOLD, S_DONE
    } state_t;

    state_t              state;
    logic [COL_W-1:0]    col_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [HEIGHT_W-1:0] pending;
    logic                calc_end_d;

    logic                cmpl;
    logic                slot_free;
    logic                last_col;
    logic                tmo_hit;
    logic [HEIGHT_W-1:0] clamped;

    // A held end level from the previous column must not count again, so
    // only the rising edge of calc_end marks completion.
    assign cmpl      = calc_end & ~calc_end_d;
    // Slot can take new data when empty or being drained this cycle.
    assign slot_free = ~slice_valid | slice_ready;
    assign last_col  = (col_cnt == COL_W'(NUM_COLS - 1));
    // Fires on the cycle the counter would reach TIMEOUT_CYC, so exactly
    // TIMEOUT_CYC cycles are spent waiting.
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign clamped   = (calc_slice_size > HEIGHT_W'(MAX_HEIGHT)) ?
                       HEIGHT_W'(MAX_HEIGHT) : calc_slice_size;

    // Delayed copy of calc_end for edge detection, tracked in every state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) calc_end_d <= 1'b0;
        else         calc_end_d <= calc_end;
    end

    // Frame FSM with registered outputs; begin pulse and column are set on
    // entry to ISSUE so they are visible during the ISSUE cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            col_cnt      <= '0;
            tmo_cnt      <= '0;
            pending      <= '0;
            calc_playerX <= '0;
            calc_playerY <= '0;
            calc_angle_X <= '0;
            calc_angle_Y <= '0;
            calc_column  <= '0;
            calc_begin   <= 1'b0;
            slice_valid  <= 1'b0;
            slice_column <= '0;
            slice_height <= '0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            calc_begin <= 1'b0;
            frame_done <= 1'b0;
            // Drain on acceptance; a HOLD reload below overrides this.
            if (slice_valid && slice_ready) slice_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        err_timeout <= 1'b0;
                        col_cnt     <= '0;
                        frame_busy  <= 1'b1;
                        state       <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Pose is frozen here so every column sees the same operands.
                    calc_playerX <= playerX;
                    calc_playerY <= playerY;
                    calc_angle_X <= angle_X;
                    calc_angle_Y <= angle_Y;
                    calc_begin   <= 1'b1;
                    calc_column  <= col_cnt;
                    state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (cmpl) begin
                        pending <= clamped;
                        state   <= S_HOLD;
                    end else if (tmo_hit) begin
                        // Dead calculator: emit an empty slice and keep sweeping.
                        pending     <= '0;
                        err_timeout <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        slice_valid  <= 1'b1;
                        slice_column <= col_cnt;
                        slice_height <= pending;
                        if (last_col) begin
                            state <= S_DONE;
                        end else begin
                            col_cnt     <= col_cnt + 1'b1;
                            calc_begin  <= 1'b1;
                            calc_column <= col_cnt + 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    // Frame ends only once the last slice has left the slot.
                    if (slot_free) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raycast_column_scheduler.sv
// Directed bench for raycast_column_scheduler with a behavioural calculator
// and a drawer monitor recording every accepted slice.
module tb_raycast_column_scheduler;
    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic               frame_start = 1'b0;
    logic signed [12:0] playerX = '0, playerY = '0;
    logic signed [9:0]  angle_X = '0, angle_Y = '0;
    logic signed [12:0] calc_playerX, calc_playerY;
    logic signed [9:0]  calc_angle_X, calc_angle_Y;
    logic [7:0]         calc_column;
    logic               calc_begin;
    logic               calc_end = 1'b0;
    logic [6:0]         calc_slice_size = '0;
    logic               slice_valid;
    logic               slice_ready = 1'b1;
    logic [7:0]         slice_column;
    logic [6:0]         slice_height;
    logic               frame_busy, frame_done, err_timeout;

    int checks = 0;
    int passed = 0;

    raycast_column_scheduler dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .playerX(playerX), .playerY(playerY), .angle_X(angle_X), .angle_Y(angle_Y),
        .calc_playerX(calc_playerX), .calc_playerY(calc_playerY),
        .calc_angle_X(calc_angle_X), .calc_angle_Y(calc_angle_Y),
        .calc_column(calc_column), .calc_begin(calc_begin), .calc_end(calc_end),
        .calc_slice_size(calc_slice_size), .slice_valid(slice_valid),
        .slice_ready(slice_ready), .slice_column(slice_column),
        .slice_height(slice_height), .frame_busy(frame_busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    // calculator model: end rises 12 cycles after begin
    bit stale = 1'b0;
    int hang_col = -1;
    int clamp_col = -1;
    int mcnt = -1;
    int cur_col = 0;
    int nb = 0;
    int begin_col[4096];
    int begin_cyc[4096];
    int cyc = 0;

    always @(negedge clock) begin
        if (!resetn) begin
            mcnt = -1;
            calc_end = 1'b0;
        end else if (calc_begin) begin
            cur_col = int'(calc_column);
            mcnt = 0;
            if (nb < 4096) begin
                begin_col[nb] = cur_col;
                begin_cyc[nb] = cyc;
            end
            nb++;
            if (!stale) calc_end = 1'b0;
        end else if (mcnt >= 0) begin
            mcnt++;
            if (stale && mcnt == 2) calc_end = 1'b0;
            if (mcnt == 12 && cur_col != hang_col) begin
                calc_end = 1'b1;
                calc_slice_size = (cur_col == clamp_col) ? 7'd127 : 7'(40 + cur_col % 60);
            end
            if (!stale && mcnt == 13) calc_end = 1'b0;
        end
    end

    // drawer monitor
    int n_acc = 0;
    int acc_col[4096];
    int acc_h[4096];
    int done_cnt = 0;

    always @(posedge clock) begin
        cyc++;
        if (slice_valid && slice_ready) begin
            if (n_acc < 4096) begin
                acc_col[n_acc] = int'(slice_column);
                acc_h[n_acc]   = int'(slice_height);
            end
            n_acc++;
        end
        if (frame_done) done_cnt++;
    end

    function automatic int exp_h(input int col);
        if (col == hang_col)  return 0;
        if (col == clamp_col) return 120;
        return 40 + col % 60;
    endfunction

    // number of wrong/missing slices for the frame recorded from index base
    function automatic int frame_errs(input int base);
        int e;
        e = (n_acc - base != 160) ? 1 : 0;
        for (int i = 0; i < 160; i++) begin
            if (base + i < 4096 && base + i < n_acc) begin
                if (acc_col[base + i] != i || acc_h[base + i] != exp_h(i)) e++;
            end
        end
        return e;
    endfunction

    task automatic start_frame;
        @(negedge clock); frame_start = 1'b1;
        @(negedge clock); frame_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 6000) begin
            @(negedge clock);
            k++;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y, calc_column, calc_begin,
             slice_valid, slice_column, slice_height, frame_busy, frame_done, err_timeout} !== '0)
            $display("FAIL reset_outputs: outputs not all zero during reset");
        else passed++;
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if ({nb, frame_busy} !== {32'd0, 1'b0})
            $display("FAIL idle_quiet: begins=%0d busy=%0b, expected 0/0", nb, frame_busy);
        else passed++;
    endtask

    task automatic test_nominal;
        int base, d0, bnb;
        bit ok;
        playerX = 13'sd1234; playerY = -13'sd77; angle_X = 10'sd45; angle_Y = -10'sd3;
        base = n_acc; d0 = done_cnt; bnb = nb;
        start_frame();
        checks++;
        if (calc_begin !== 1'b0) $display("FAIL latch_cycle_begin: got %0b exp 0", calc_begin);
        else passed++;
        @(negedge clock);
        checks++;
        if ({calc_begin, calc_column} !== {1'b1, 8'd0})
            $display("FAIL first_begin: begin=%0b col=%0d exp 1/0", calc_begin, calc_column);
        else passed++;
        checks++;
        if ({calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y} !==
            {13'sd1234, -13'sd77, 10'sd45, -10'sd3})
            $display("FAIL operand_latch: X=%0d Y=%0d aX=%0d aY=%0d exp 1234/-77/45/-3",
                     calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y);
        else passed++;
        checks++;
        if (frame_busy !== 1'b1) $display("FAIL busy_in_frame: got %0b exp 1", frame_busy);
        else passed++;
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL nominal_done_timeout: frame_done not seen");
        else passed++;
        repeat (5) @(negedge clock);
        checks++;
        if (done_cnt - d0 != 1) $display("FAIL nominal_done_count: got %0d exp 1", done_cnt - d0);
        else passed++;
        checks++;
        if (frame_busy !== 1'b0) $display("FAIL busy_after_frame: got %0b exp 0", frame_busy);
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL nominal_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
        checks++;
        if (begin_cyc[bnb + 1] - begin_cyc[bnb] != 14)
            $display("FAIL begin_spacing: got %0d exp 14", begin_cyc[bnb + 1] - begin_cyc[bnb]);
        else passed++;
        checks++;
        if (nb - bnb != 160) $display("FAIL nominal_begins: got %0d exp 160", nb - bnb);
        else passed++;
    endtask

    task automatic test_backpressure;
        int base, d0, k, bad;
        bit ok;
        base = n_acc; d0 = done_cnt;
        start_frame();
        k = 0;
        while (!(slice_valid && slice_column == 8'd5) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        slice_ready = 1'b0;
        checks++;
        if (k >= 2000) $display("FAIL bp_col5_seen: column 5 never presented");
        else passed++;
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (!(slice_valid === 1'b1 && slice_column === 8'd5 && slice_height === 7'd45)) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL bp_hold_stable: %0d unstable cycles exp 0", bad);
        else passed++;
        checks++;
        if (begin_col[nb - 1] != 6) $display("FAIL bp_no_col7: last begin col %0d exp 6", begin_col[nb - 1]);
        else passed++;
        checks++;
        if (frame_busy !== 1'b1) $display("FAIL bp_busy: got %0b exp 1", frame_busy);
        else passed++;
        slice_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({slice_valid, slice_column, slice_height} !== {1'b1, 8'd6, 7'd46})
            $display("FAIL bp_reload: v=%0b col=%0d h=%0d exp 1/6/46", slice_valid, slice_column, slice_height);
        else passed++;
        checks++;
        if ({calc_begin, calc_column} !== {1'b1, 8'd7})
            $display("FAIL bp_col7_begin: begin=%0b col=%0d exp 1/7", calc_begin, calc_column);
        else passed++;
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL bp_done_timeout: frame_done not seen");
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL bp_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
    endtask

    task automatic test_stale_end;
        int base, d0, bnb;
        bit ok;
        stale = 1'b1;
        base = n_acc; d0 = done_cnt; bnb = nb;
        start_frame();
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL stale_done_timeout: frame_done not seen");
        else passed++;
        checks++;
        if (nb - bnb != 160) $display("FAIL stale_begins: got %0d exp 160", nb - bnb);
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL stale_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
        stale = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_timeout_clamp;
        int base, d0, k;
        bit ok;
        hang_col = 3; clamp_col = 4;
        base = n_acc; d0 = done_cnt;
        start_frame();
        k = 0;
        while (!(calc_begin && calc_column == 8'd3) && k < 500) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (err_timeout !== 1'b0) $display("FAIL tmo_err_before: got %0b exp 0", err_timeout);
        else passed++;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(slice_valid && slice_column == 8'd3) && k < 400);
        checks++;
        if (k != 257) $display("FAIL tmo_latency: begin-to-slice %0d cycles exp 257", k);
        else passed++;
        checks++;
        if ({err_timeout, slice_height} !== {1'b1, 7'd0})
            $display("FAIL tmo_slice: err=%0b h=%0d exp 1/0", err_timeout, slice_height);
        else passed++;
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL tmo_done_timeout: frame_done not seen");
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL tmo_clamp_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
        checks++;
        if (acc_h[base + 4] != 120) $display("FAIL clamp_col4: got %0d exp 120", acc_h[base + 4]);
        else passed++;
        repeat (3) @(negedge clock);
        checks++;
        if (err_timeout !== 1'b1) $display("FAIL tmo_err_sticky: got %0b exp 1", err_timeout);
        else passed++;
        hang_col = -1; clamp_col = -1;
    endtask

    task automatic test_latch_ignore;
        int base, d0, bnb, zeros;
        bit ok;
        playerX = 13'sd100;
        base = n_acc; d0 = done_cnt; bnb = nb;
        start_frame();
        checks++;
        if (err_timeout !== 1'b0) $display("FAIL err_cleared: got %0b exp 0", err_timeout);
        else passed++;
        repeat (300) @(negedge clock);
        playerX = 13'sd555;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (calc_playerX !== 13'sd100) $display("FAIL latch_hold: got %0d exp 100", calc_playerX);
        else passed++;
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL ign_done_timeout: frame_done not seen");
        else passed++;
        repeat (5) @(negedge clock);
        zeros = 0;
        for (int i = bnb; i < nb && i < 4096; i++) if (begin_col[i] == 0) zeros++;
        checks++;
        if (zeros != 1) $display("FAIL ign_no_restart: col0 begins %0d exp 1", zeros);
        else passed++;
        checks++;
        if (done_cnt - d0 != 1) $display("FAIL ign_done_count: got %0d exp 1", done_cnt - d0);
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL ign_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int base, d0, k;
        bit ok;
        d0 = done_cnt;
        start_frame();
        k = 0;
        while (!(calc_begin && calc_column == 8'd80) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k >= 2000) $display("FAIL rst_col80_seen: column 80 never issued");
        else passed++;
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({calc_playerX, calc_playerY, calc_angle_X, calc_angle_Y, calc_column, calc_begin,
             slice_valid, slice_column, slice_height, frame_busy, frame_done, err_timeout} !== '0)
            $display("FAIL rst_async_zero: outputs not all zero right after reset");
        else passed++;
        @(negedge clock);
        #1 resetn = 1'b1;
        repeat (20) @(negedge clock);
        checks++;
        if ({done_cnt - d0, frame_busy} !== {32'd0, 1'b0})
            $display("FAIL rst_no_done: dones=%0d busy=%0b exp 0/0", done_cnt - d0, frame_busy);
        else passed++;
        base = n_acc; d0 = done_cnt;
        start_frame();
        @(negedge clock);
        checks++;
        if ({calc_begin, calc_column} !== {1'b1, 8'd0})
            $display("FAIL rst_restart_col0: begin=%0b col=%0d exp 1/0", calc_begin, calc_column);
        else passed++;
        wait_done(d0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL rst_done_timeout: frame_done not seen");
        else passed++;
        checks++;
        if (frame_errs(base) != 0) $display("FAIL rst_slices: %0d errors exp 0", frame_errs(base));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_stale_end();
        test_timeout_clamp();
        test_latch_ignore();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/raycast_column_scheduler.md
Name: raycast_column_scheduler

Overview:
- Frame-level sequencer for the slice-height calculator (find_slice_height).
- Sweeps the column index 0..NUM_COLS-1 and pulses the calculator's begin_calc once per column. Detects end_calc, clamps the returned slice height, and hands {column, height} to the slice drawer through a valid/ready port.
- Latches the player pose once per frame, so every column of a frame uses identical operands.

Parameters:
NUM_COLS, 160, columns per frame; column index width 8 bits
HEIGHT_W, 7, slice height width; matches slice_size
MAX_HEIGHT, 120, heights above this are clamped to it
TIMEOUT_CYC, 255, max cycles spent in WAIT_CALC per column; counter 8 bits

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
frame_start  in  1  request a new frame; sampled only in IDLE
playerX, playerY  in  13 signed  player position
angle_X, angle_Y  in  10 signed  view angle (integer, fraction)
calc_playerX, calc_playerY  out  13 signed  latched position driven to calculator
calc_angle_X, calc_angle_Y  out  10 signed  latched angle driven to calculator
calc_column  out  8  column_count driven to calculator
calc_begin  out  1  one-cycle begin_calc pulse
calc_end  in  1  calculator end_calc; level, may stay high after completion
calc_slice_size  in  HEIGHT_W  calculator result
slice_valid  out  1  slice output holds data
slice_ready  in  1  drawer accepts on slice_valid & slice_ready
slice_column  out  8  column of the presented slice
slice_height  out  HEIGHT_W  clamped height
frame_busy  out  1  high from LATCH through DONE
frame_done  out  1  one-cycle pulse at frame end
err_timeout  out  1  sticky; cleared on accepted frame_start

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0, column counter 0, pending register 0, calc_end_d 0.
- Completion event: calc_end & ~calc_end_d, where calc_end_d is calc_end registered every cycle.
  - A level held high from the previous column is never counted again.
- States:
  - IDLE: if frame_start, go to LATCH. Clear err_timeout. Column counter := 0. frame_start in any other state is ignored.
  - LATCH: register playerX/Y and angle_X/Y into the calc_* outputs, which hold until the next LATCH. Go to ISSUE.
  - ISSUE: calc_begin=1 for exactly this cycle. calc_column = counter. Timeout counter := 0. Go to WAIT_CALC.
  - WAIT_CALC: timeout counter increments each cycle.
    - On a completion event: pending := min(calc_slice_size, MAX_HEIGHT); go to HOLD.
    - Else, if the timeout counter reaches TIMEOUT_CYC: pending := 0; err_timeout := 1; go to HOLD.
    - A completion event and the timeout in the same cycle resolve as completion.
  - HOLD: the output slot is free if slice_valid=0, or slice_valid & slice_ready this cycle.
    - If free: slice_column := counter; slice_height := pending; slice_valid := 1 next cycle.
      - Then, if counter = NUM_COLS-1, go to DONE; else counter++ and go to ISSUE.
    - If not free: stay in HOLD. No new calc_begin is issued.
  - DONE: wait until the slot is free and no new data is loaded. Then pulse frame_done for 1 cycle, go to IDLE, frame_busy := 0.
- Output slot: slice_valid clears on acceptance unless HOLD reloads the slot in the same cycle.
  - slice_column and slice_height are stable while slice_valid=1 and slice_ready=0.
- Overlap: the calculation for column n+1 runs while slice n waits on the drawer. Depth is one output register plus one pending register.
- Latency, no backpressure: calc_begin for column 0 comes 2 cycles after frame_start is sampled. The next column's begin comes 2 cycles after its predecessor's completion event (HOLD, ISSUE).
- The counter never wraps within a frame; every column appears exactly once, in ascending order.
- Reset mid-frame aborts immediately. No frame_done is generated. The next frame restarts at column 0.

Test Plan:
- Nominal: model calculator with end rising 12 cycles after begin, height 40+col mod 60, slice_ready=1.
  -> 160 slices with columns 0..159 in order and correct heights; exactly one frame_done; frame_busy low afterwards.
- Backpressure: slice_ready=0 for 50 cycles while column 5 is presented.
  -> column 5 held stable; column 6 computes and waits in HOLD; no calc_begin for column 7 until column 5 is accepted.
- Stale end level: model holds calc_end high until 2 cycles after the next begin.
  -> exactly one slice per column; no skipped or duplicated columns.
- Timeout and clamp: column 3 never ends; column 4 returns 127.
  -> after 255 WAIT cycles, slice {3,0} and err_timeout=1 (held through the frame); column 4 yields height 120.
  -> next frame_start clears err_timeout.
- Operand latch and ignore: change playerX and pulse frame_start mid-frame.
  -> calc_playerX unchanged and no restart until IDLE.
- Reset at column 80: resetn low for 1 cycle.
  -> all outputs 0 asynchronously; next frame starts with calc_column=0.
